// File: rtl/kernel_cc_start_fifo_fanout_pkg.sv
// kernel_cc_fifo_pkg
// Shared definitions for the kernel_cc start-token FIFOs: a constant-foldable
// clog2, default geometry and the status encoding used when deriving the
// registered empty/full flags from the next occupancy count.

package kernel_cc_fifo_pkg;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Default geometry of a start FIFO: four entries, pointer wide enough to
  // index them, and a count one bit wider so it can hold the value DEPTH.
  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_ADDR_WIDTH  = clog2(DEFAULT_DEPTH);
  localparam int DEFAULT_COUNT_WIDTH = DEFAULT_ADDR_WIDTH + 1;

  // Occupancy status. The FIFO_EMPTY / FIFO_FULL codes are shared with the
  // single-consumer start FIFOs so status buses look alike across the region.
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'b00,
    FIFO_PARTIAL = 2'b01,
    FIFO_FULL    = 2'b10
  } fifo_status_t;

endpackage : kernel_cc_fifo_pkg

// File: rtl/kernel_cc_start_fifo_fanout_if.sv
// kernel_cc_start_fifo_fanout_if
// Producer/consumer handshake bundle of the fan-out start FIFO.
// The master side is the producer task plus the consumer tasks; the slave
// side is the FIFO itself. The if_almost_full_n flag only exists when
// KERNEL_CC_START_FIFO_ALMOST_FULL_EN is defined.

interface kernel_cc_start_fifo_fanout_if
  import kernel_cc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_CONS   = 2
);

  // Producer side
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;

  // Consumer side: one empty_n/read pair per consumer, a shared data bus
  logic [NUM_CONS-1:0]   if_empty_n;
  logic                  if_read_ce;
  logic [NUM_CONS-1:0]   if_read;
  logic [DATA_WIDTH-1:0] if_dout;

  // Status
  logic [ADDR_WIDTH:0]   if_count;
`ifdef KERNEL_CC_START_FIFO_ALMOST_FULL_EN
  logic                  if_almost_full_n;
`endif

  modport master (
    input  if_full_n, if_empty_n, if_dout, if_count,
`ifdef KERNEL_CC_START_FIFO_ALMOST_FULL_EN
           if_almost_full_n,
`endif
    output if_write_ce, if_write, if_din, if_read_ce, if_read
  );

  modport slave (
    output if_full_n, if_empty_n, if_dout, if_count,
`ifdef KERNEL_CC_START_FIFO_ALMOST_FULL_EN
           if_almost_full_n,
`endif
    input  if_write_ce, if_write, if_din, if_read_ce, if_read
  );

endinterface : kernel_cc_start_fifo_fanout_if

// File: rtl/kernel_cc_start_fifo_fanout_shiftReg.sv
// kernel_cc_start_fifo_fanout_shiftReg
// Token storage only: a shift register that inserts at index 0 on every
// enabled cycle and is read combinationally at an arbitrary index. It holds
// no reset because the count in the parent decides which entries are valid.

module kernel_cc_start_fifo_fanout_shiftReg
  import kernel_cc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] srl [DEPTH];

  // Shift every entry one place towards the tail and insert the new token at 0
  always_ff @(posedge clk) begin
    if (ce) begin
      srl[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        srl[i] <= srl[i-1];
      end
    end
  end

  assign q = srl[a];

endmodule : kernel_cc_start_fifo_fanout_shiftReg

// File: rtl/kernel_cc_start_fifo_fanout.sv
// kernel_cc_start_fifo_fanout
// Start-token FIFO with one producer and NUM_CONS consumers. The head entry
// stays in place until every consumer has read it once; a per-consumer
// "taken" bit hides the head from consumers that have already been served.
// Optional feature: define KERNEL_CC_START_FIFO_ALMOST_FULL_EN to add the
// registered if_almost_full_n flag (threshold AF_THRESH).

module kernel_cc_start_fifo_fanout
  import kernel_cc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int NUM_CONS   = 2
`ifdef KERNEL_CC_START_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH  = 3
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  kernel_cc_start_fifo_fanout_if.slave bus
);

  localparam int                CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  // Registered state
  logic [CNT_W-1:0]    count;
  logic                empty_int;
  logic                full_n;
  logic [NUM_CONS-1:0] taken;

  // Combinational handshake and next-state values
  logic [CNT_W-1:0]      count_next;
  logic [NUM_CONS-1:0]   taken_next;
  logic [NUM_CONS-1:0]   empty_n;
  logic [NUM_CONS-1:0]   rd_acc;
  logic                  wr_acc;
  logic                  pop;
  fifo_status_t          status_next;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic [DATA_WIDTH-1:0] head_data;

  // Accept decisions use only registered flags, so a write while full is
  // dropped even if the head retires in the same cycle.
  always_comb begin
    empty_n = {NUM_CONS{empty_int}} & ~taken;
    wr_acc  = bus.if_write & bus.if_write_ce & full_n;
    rd_acc  = bus.if_read & {NUM_CONS{bus.if_read_ce}} & empty_n;
    pop     = empty_int & (&(taken | rd_acc));
  end

  // Next occupancy, taken vector and the status they imply
  always_comb begin
    taken_next  = taken | rd_acc;
    count_next  = count;
    status_next = FIFO_PARTIAL;
    if (pop) begin
      taken_next = '0;
    end
    if (wr_acc && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !wr_acc) begin
      count_next = count - CNT_ONE;
    end
    if (count_next == CNT_ZERO) begin
      status_next = FIFO_EMPTY;
    end else if (count_next == CNT_DEPTH) begin
      status_next = FIFO_FULL;
    end
  end

  // Count, flags and taken bits; reset empties the FIFO and clears all reads
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= CNT_ZERO;
      empty_int <= 1'b0;
      full_n    <= 1'b1;
      taken     <= '0;
    end else begin
      count     <= count_next;
      empty_int <= (status_next != FIFO_EMPTY);
      full_n    <= (status_next != FIFO_FULL);
      taken     <= taken_next;
    end
  end

`ifdef KERNEL_CC_START_FIFO_ALMOST_FULL_EN
  logic almost_full_n;

  // Almost-full flag, registered from the next count like the other flags
  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_n <= 1'b1;
    end else begin
      almost_full_n <= (count_next < CNT_W'(AF_THRESH));
    end
  end

  assign bus.if_almost_full_n = almost_full_n;
`endif

  // The oldest token sits at count-1 because new tokens enter at index 0
  always_comb begin
    head_idx = '0;
    if (count != CNT_ZERO) begin
      head_idx = ADDR_WIDTH'(count - CNT_ONE);
    end
  end

  kernel_cc_start_fifo_fanout_shiftReg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .data (bus.if_din),
    .ce   (wr_acc),
    .a    (head_idx),
    .q    (head_data)
  );

  assign bus.if_full_n  = full_n;
  assign bus.if_empty_n = empty_n;
  assign bus.if_count   = count;
  assign bus.if_dout    = head_data;

endmodule : kernel_cc_start_fifo_fanout
